// File: rtl/conv3x3_mac_scheduler_if.sv
// Handshake and multiplier-port bundle for conv3x3_mac_scheduler.
// slave is the scheduler's view; master is the window source / multiplier / sink view.
interface conv3x3_mac_scheduler_if #(
   parameter int ACC_W = 20
);
   logic                    in_valid;
   logic                    in_ready;
   logic [71:0]             pix_in;
   logic [71:0]             coef_in;
   logic [7:0]              mul_a;
   logic [7:0]              mul_b;
   logic signed [15:0]      mul_p;
   logic                    out_valid;
   logic                    out_ready;
   logic signed [ACC_W-1:0] acc_out;
   logic                    busy;

   modport slave (
      input  in_valid, pix_in, coef_in, mul_p, out_ready,
      output in_ready, mul_a, mul_b, out_valid, acc_out, busy
   );

   modport master (
      output in_valid, pix_in, coef_in, mul_p, out_ready,
      input  in_ready, mul_a, mul_b, out_valid, acc_out, busy
   );
endinterface

// File: rtl/conv3x3_mac_scheduler.sv
// Time-multiplexes one external 8x8 multiplier over the 9 taps of a 3x3 window and
// accumulates the products. Optional ReLU/clamp output stage via CONV_RELU_CLAMP_EN.
module conv3x3_mac_scheduler #(
   parameter int ACC_W = 20
`ifdef CONV_RELU_CLAMP_EN
   , parameter int SHIFT = 0
`endif
) (
   input logic                      clk,
   input logic                      rst,
   conv3x3_mac_scheduler_if.slave   bus
);

   typedef enum logic [1:0] {IDLE, MAC, DRAIN, OUT} state_e;

   state_e                  state_q, state_d;
   logic [3:0]              k_q;
   logic [71:0]             pix_q, coef_q;
   logic signed [15:0]      prod_q;
   logic                    pv_q;
   logic signed [ACC_W-1:0] acc_q, res_q;
   logic signed [ACC_W-1:0] acc_sum;
   logic                    accept;

`ifdef CONV_RELU_CLAMP_EN
   function automatic logic signed [ACC_W-1:0] relu_clamp(input logic signed [ACC_W-1:0] v);
      logic signed [ACC_W-1:0] s;
      s = v >>> SHIFT;
      if (s < 0)        return '0;
      else if (s > 255) return ACC_W'(255);
      else              return s;
   endfunction
`endif

   // The product register lags the multiply by one cycle, so the last tap lands in DRAIN.
   assign acc_sum = acc_q + ACC_W'(prod_q);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d       = state_q;
      accept        = 1'b0;
      bus.in_ready  = 1'b0;
      bus.out_valid = 1'b0;
      bus.busy      = 1'b1;
      bus.mul_a     = '0;
      bus.mul_b     = '0;
      case (state_q)
         IDLE: begin
            bus.busy     = 1'b0;
            bus.in_ready = 1'b1;
            if (bus.in_valid) begin
               accept  = 1'b1;
               state_d = MAC;
            end
         end
         MAC: begin
            bus.mul_a = pix_q[{k_q, 3'b000} +: 8];
            bus.mul_b = coef_q[{k_q, 3'b000} +: 8];
            if (k_q == 4'd8) state_d = DRAIN;
         end
         DRAIN: state_d = OUT;
         OUT: begin
            bus.out_valid = 1'b1;
            if (bus.out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         k_q    <= '0;
         pix_q  <= '0;
         coef_q <= '0;
         prod_q <= '0;
         pv_q   <= 1'b0;
         acc_q  <= '0;
         res_q  <= '0;
      end else begin
         if (accept) begin
            pix_q  <= bus.pix_in;
            coef_q <= bus.coef_in;
            acc_q  <= '0;
            k_q    <= '0;
         end
         if (state_q == MAC) begin
            prod_q <= bus.mul_p;
            k_q    <= k_q + 4'd1;
         end
         pv_q <= (state_q == MAC);
         if (pv_q) acc_q <= acc_sum;
         // Result register holds the previous window's value until the next DRAIN.
         if (state_q == DRAIN) begin
`ifdef CONV_RELU_CLAMP_EN
            res_q <= relu_clamp(acc_sum);
`else
            res_q <= acc_sum;
`endif
         end
      end
   end

   assign bus.acc_out = res_q;

endmodule
